// File: rtl/ahb_slave_arbiter.sv
// Per-slave round-robin address-phase arbiter with burst/lock hold and a
// registered data-phase select that trails the grant by one accepted transfer.
module ahb_slave_arbiter #(
  parameter int MASTER_NUM = 4,
  parameter int ID_W       = $clog2(MASTER_NUM)
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic [MASTER_NUM-1:0] req,
  input  logic [MASTER_NUM-1:0] seq,
  input  logic [MASTER_NUM-1:0] lock,
  input  logic                  hready,
  output logic [MASTER_NUM-1:0] hgrant,
  output logic [MASTER_NUM-1:0] data_sel,
  output logic [ID_W-1:0]       owner_id,
  output logic                  owner_valid
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                state_q;
  logic [MASTER_NUM-1:0] owner_q;
  logic [MASTER_NUM-1:0] dsel_q;
  logic [ID_W-1:0]       ptr_q;
  logic [ID_W-1:0]       id_q;

  logic                  keep;
  logic [ID_W-1:0]       pick;

  // First requester after the last granted index, wrapping modulo MASTER_NUM.
  function automatic logic [ID_W-1:0] rr_pick(input logic [MASTER_NUM-1:0] r,
                                               input logic [ID_W-1:0]       p);
    logic [ID_W-1:0] sel;
    logic            found;
    int              idx;
    sel   = '0;
    found = 1'b0;
    for (int i = 1; i <= MASTER_NUM; i++) begin
      idx = (int'(p) + i) % MASTER_NUM;
      if (!found && r[ID_W'(idx)]) begin
        sel   = ID_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // req gates the hold, so an owner that drops req is released even with seq/lock high.
  assign keep = |(owner_q & req & (seq | lock));
  assign pick = rr_pick(req, ptr_q);

  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      dsel_q  <= '0;
      ptr_q   <= ID_W'(MASTER_NUM - 1);
      id_q    <= '0;
    end else if (hready) begin
      dsel_q <= (|(owner_q & req)) ? owner_q : '0;
      if (!(state_q == OWNED && keep)) begin
        if (|req) begin
          state_q <= OWNED;
          owner_q <= MASTER_NUM'(1) << pick;
          ptr_q   <= pick;
          id_q    <= pick;
        end else begin
          state_q <= IDLE;
          owner_q <= '0;
          id_q    <= '0;
        end
      end
    end
  end

  assign hgrant      = owner_q;
  assign data_sel    = dsel_q;
  assign owner_id    = id_q;
  assign owner_valid = (state_q == OWNED);

endmodule
